// File: rtl/vga_fb_blitter.sv
// Purpose: bus-mapped pixel engine that plots single pixels or fills rectangles into a frame buffer.
// Latency: first FB write in the cycle after the command edge, then one pixel per cycle.
// Backpressure: none; bus writes that arrive while BUSY are dropped and flagged in STATUS.ERR.
//
// Ports: CLK/RESET (async, active low); BUS_DATA/BUS_ADDR/BUS_WE form an 8-register bus window
// at BASE_ADDR; FB_ADDR={Y,X}, FB_DATA and FB_WE drive the frame-buffer write port; BUSY = not idle.
// X_WIDTH, Y_WIDTH and COLOUR_WIDTH must each be at most 8, since registers load from the 8-bit bus.
module vga_fb_blitter #(
    parameter logic [7:0] BASE_ADDR    = 8'hB0,
    parameter int         X_WIDTH      = 8,
    parameter int         Y_WIDTH      = 7,
    parameter int         COLOUR_WIDTH = 8,
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119
) (
    input  logic                       CLK,
    input  logic                       RESET,
    inout  wire  [7:0]                 BUS_DATA,
    input  logic [7:0]                 BUS_ADDR,
    input  logic                       BUS_WE,
    output logic [X_WIDTH+Y_WIDTH-1:0] FB_ADDR,
    output logic [COLOUR_WIDTH-1:0]    FB_DATA,
    output logic                       FB_WE,
    output logic                       BUSY
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLOT = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_MAX);

    logic [1:0]              state_q, state_d;
    logic [X_WIDTH-1:0]      x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
    logic [Y_WIDTH-1:0]      y0_q, y0_d, y1_q, y1_d, cy_q, cy_d;
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
    logic                    autoinc_q, autoinc_d;
    logic                    err_q, err_d;

    logic [7:0] rel_addr;
    logic [2:0] off;
    logic       in_win, wr_en, rd_en, busy;
    logic       new_err, clr_err, start_plot, start_fill;
    logic [7:0] rd_dat;

    // Window decode by subtraction: any address below BASE wraps to a large offset.
    assign rel_addr = BUS_ADDR - BASE_ADDR;
    assign in_win   = (rel_addr[7:3] == 5'd0);
    assign off      = rel_addr[2:0];
    assign wr_en    = in_win & BUS_WE;
    assign rd_en    = in_win & ~BUS_WE & RESET;
    assign busy     = (state_q != ST_IDLE);

    // Register file and command decode.
    always_comb begin
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        colour_d   = colour_q;
        autoinc_d  = autoinc_q;
        new_err    = 1'b0;
        clr_err    = 1'b0;
        start_plot = 1'b0;
        start_fill = 1'b0;
        if (wr_en) begin
            case (off)
                3'd0: if (busy) new_err = 1'b1; else x0_d = BUS_DATA[X_WIDTH-1:0];
                3'd1: if (busy) new_err = 1'b1; else y0_d = BUS_DATA[Y_WIDTH-1:0];
                3'd2: begin
                    if (busy) begin
                        new_err = 1'b1;
                    end else begin
                        colour_d   = BUS_DATA[COLOUR_WIDTH-1:0];
                        start_plot = autoinc_q;
                    end
                end
                3'd3: begin
                    if (busy) begin
                        new_err = 1'b1;
                    end else begin
                        clr_err = BUS_DATA[7];
                        // FILL takes priority over PLOT when both bits are set.
                        if (BUS_DATA[1]) begin
                            if (x1_q < x0_q || y1_q < y0_q) new_err = 1'b1;
                            else                            start_fill = 1'b1;
                        end else if (BUS_DATA[0]) begin
                            start_plot = 1'b1;
                        end
                    end
                end
                3'd4: if (busy) new_err = 1'b1; else x1_d = BUS_DATA[X_WIDTH-1:0];
                3'd5: if (busy) new_err = 1'b1; else y1_d = BUS_DATA[Y_WIDTH-1:0];
                3'd7: autoinc_d = BUS_DATA[0];
                default: ;
            endcase
        end

        // A new error on the same edge as a clear wins.
        err_d = (err_q & ~clr_err) | new_err;

        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        case (state_q)
            ST_IDLE: begin
                if (start_fill || start_plot) begin
                    state_d = start_fill ? ST_FILL : ST_PLOT;
                    cx_d    = x0_q;
                    cy_d    = y0_q;
                end
            end
            ST_PLOT: begin
                state_d = ST_IDLE;
                // Bus writes are locked out while busy, so this cannot race a register write.
                if (autoinc_q) begin
                    if (x0_q == X_LAST) begin
                        x0_d = '0;
                        y0_d = (y0_q == Y_LAST) ? '0 : y0_q + Y_WIDTH'(1);
                    end else begin
                        x0_d = x0_q + X_WIDTH'(1);
                    end
                end
            end
            ST_FILL: begin
                if (cx_q == x1_q) begin
                    cx_d = x0_q;
                    if (cy_q == y1_q) state_d = ST_IDLE;
                    else              cy_d = cy_q + Y_WIDTH'(1);
                end else begin
                    cx_d = cx_q + X_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            colour_q  <= '0;
            autoinc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            colour_q  <= colour_d;
            autoinc_q <= autoinc_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        rd_dat = 8'h00;
        case (off)
            3'd0: rd_dat = 8'(x0_q);
            3'd1: rd_dat = 8'(y0_q);
            3'd2: rd_dat = 8'(colour_q);
            3'd4: rd_dat = 8'(x1_q);
            3'd5: rd_dat = 8'(y1_q);
            3'd6: rd_dat = {6'd0, err_q, busy};
            3'd7: rd_dat = {7'd0, autoinc_q};
            default: rd_dat = 8'h00;
        endcase
    end

    assign BUS_DATA = rd_en ? rd_dat : 8'bz;

    // Off-screen pixels still occupy a scan cycle; only the strobe is suppressed.
    assign FB_ADDR = {cy_q, cx_q};
    assign FB_DATA = colour_q;
    assign FB_WE   = busy && (cx_q <= X_LAST) && (cy_q <= Y_LAST);
    assign BUSY    = busy;

endmodule

// File: tb/tb_vga_fb_blitter.sv
module tb_vga_fb_blitter;

    localparam logic [7:0] BASE = 8'hB0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  bus_addr = 8'h00;
    logic        bus_we = 1'b0;
    logic        tb_drv = 1'b0;
    logic [7:0]  tb_dat = 8'h00;
    wire  [7:0]  bus_data;
    logic [14:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    assign bus_data = tb_drv ? tb_dat : 8'bz;

    vga_fb_blitter dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .BUS_DATA (bus_data),
        .BUS_ADDR (bus_addr),
        .BUS_WE   (bus_we),
        .FB_ADDR  (fb_addr),
        .FB_DATA  (fb_data),
        .FB_WE    (fb_we),
        .BUSY     (busy)
    );

    always #5 clk = ~clk;

    // Expected per-cycle trace (model) and observed trace.
    logic        exp_we[$];
    logic        exp_busy[$];
    logic [14:0] exp_addr[$];
    logic [7:0]  exp_dat[$];
    logic        obs_we[$];
    logic        obs_busy[$];
    logic [14:0] obs_addr[$];
    logic [7:0]  obs_dat[$];

    // Reference: row-major rectangle scan, off-screen pixels suppressed, then one idle cycle.
    function automatic void build_expect(int x0, int y0, int x1, int y1, logic [7:0] col);
        exp_we.delete(); exp_busy.delete(); exp_addr.delete(); exp_dat.delete();
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                exp_we.push_back((x <= 159) && (y <= 119));
                exp_busy.push_back(1'b1);
                exp_addr.push_back(15'(y * 256 + x));
                exp_dat.push_back(col);
            end
        end
        exp_we.push_back(1'b0);
        exp_busy.push_back(1'b0);
        exp_addr.push_back(15'd0);
        exp_dat.push_back(8'd0);
    endfunction

    task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
        @(negedge clk);
        bus_addr = BASE + 8'(off);
        bus_we   = 1'b1;
        tb_dat   = d;
        tb_drv   = 1'b1;
        @(posedge clk);
        #1;
        bus_we   = 1'b0;
        tb_drv   = 1'b0;
        bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [7:0] d);
        @(negedge clk);
        bus_addr = BASE + 8'(off);
        bus_we   = 1'b0;
        #1;
        d = bus_data;
        bus_addr = 8'h00;
    endtask

    task automatic capture(input int n);
        obs_we.delete(); obs_busy.delete(); obs_addr.delete(); obs_dat.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            obs_we.push_back(fb_we);
            obs_busy.push_back(busy);
            obs_addr.push_back(fb_addr);
            obs_dat.push_back(fb_data);
        end
    endtask

    task automatic test_reset;
        logic [7:0] rd;
        #2;
        n_checks++;
        if (fb_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: fb_we=%b busy=%b, expected 0 0", fb_we, busy);
        end
        #20;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            n_checks++;
            if (rd !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg%0d: read %h, expected 00", i, rd);
            end
        end
    endtask

    task automatic test_plot;
        // Pixel at the origin.
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h00);
        bus_write(3'd2, 8'h01);
        bus_write(3'd3, 8'h01);
        build_expect(0, 0, 0, 0, 8'h01);
        capture(exp_we.size());
        for (int i = 0; i < exp_we.size(); i++) begin
            n_checks++;
            if (obs_we[i] !== exp_we[i] || obs_busy[i] !== exp_busy[i] ||
                (exp_we[i] && (obs_addr[i] !== exp_addr[i] || obs_dat[i] !== exp_dat[i]))) begin
                n_fail++;
                $display("FAIL plot_origin c%0d: we=%b busy=%b addr=%h dat=%h, expected we=%b busy=%b addr=%h dat=%h",
                         i, obs_we[i], obs_busy[i], obs_addr[i], obs_dat[i], exp_we[i], exp_busy[i], exp_addr[i], exp_dat[i]);
            end
        end
        // Address concatenation {Y,X} = 0x0BB8; X=184 is off-screen so the strobe stays low.
        bus_write(3'd0, 8'hB8);
        bus_write(3'd1, 8'h0B);
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h01);
        build_expect(8'hB8, 8'h0B, 8'hB8, 8'h0B, 8'h00);
        capture(exp_we.size());
        n_checks++;
        if (obs_addr[0] !== 15'd3000 || obs_dat[0] !== 8'h00 || obs_busy[0] !== 1'b1 || obs_we[0] !== exp_we[0]) begin
            n_fail++;
            $display("FAIL plot_addr3000: addr=%0d dat=%h busy=%b we=%b, expected addr=3000 dat=00 busy=1 we=%b",
                     obs_addr[0], obs_dat[0], obs_busy[0], obs_we[0], exp_we[0]);
        end
        n_checks++;
        if (obs_busy[1] !== 1'b0 || obs_we[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL plot_addr3000_end: busy=%b we=%b, expected 0 0", obs_busy[1], obs_we[1]);
        end
    endtask

    task automatic test_fill;
        int rect [2][4] = '{'{2, 3, 4, 4}, '{158, 0, 161, 0}};
        int pulses;
        for (int r = 0; r < 2; r++) begin
            bus_write(3'd0, 8'(rect[r][0]));
            bus_write(3'd1, 8'(rect[r][1]));
            bus_write(3'd4, 8'(rect[r][2]));
            bus_write(3'd5, 8'(rect[r][3]));
            bus_write(3'd2, 8'h5A);
            bus_write(3'd3, 8'h02);
            build_expect(rect[r][0], rect[r][1], rect[r][2], rect[r][3], 8'h5A);
            capture(exp_we.size());
            pulses = 0;
            for (int i = 0; i < exp_we.size(); i++) begin
                if (obs_we[i] === 1'b1) pulses++;
                n_checks++;
                if (obs_we[i] !== exp_we[i] || obs_busy[i] !== exp_busy[i] ||
                    (exp_we[i] && (obs_addr[i] !== exp_addr[i] || obs_dat[i] !== exp_dat[i]))) begin
                    n_fail++;
                    $display("FAIL fill%0d c%0d: we=%b busy=%b addr=%h dat=%h, expected we=%b busy=%b addr=%h dat=%h",
                             r, i, obs_we[i], obs_busy[i], obs_addr[i], obs_dat[i], exp_we[i], exp_busy[i], exp_addr[i], exp_dat[i]);
                end
            end
            n_checks++;
            if (pulses != ((r == 0) ? 6 : 2)) begin
                n_fail++;
                $display("FAIL fill%0d_pulses: %0d, expected %0d", r, pulses, (r == 0) ? 6 : 2);
            end
        end
    endtask

    task automatic test_autoinc;
        int mx = 159;
        int my = 119;
        logic [7:0] col;
        logic [7:0] rd;
        bus_write(3'd7, 8'h01);
        bus_write(3'd0, 8'd159);
        bus_write(3'd1, 8'd119);
        for (int k = 0; k < 3; k++) begin
            col = 8'($urandom_range(0, 255));
            bus_write(3'd2, col);
            build_expect(mx, my, mx, my, col);
            capture(exp_we.size());
            for (int i = 0; i < exp_we.size(); i++) begin
                n_checks++;
                if (obs_we[i] !== exp_we[i] || obs_busy[i] !== exp_busy[i] ||
                    (exp_we[i] && (obs_addr[i] !== exp_addr[i] || obs_dat[i] !== exp_dat[i]))) begin
                    n_fail++;
                    $display("FAIL autoinc%0d c%0d: we=%b busy=%b addr=%h dat=%h, expected we=%b busy=%b addr=%h dat=%h",
                             k, i, obs_we[i], obs_busy[i], obs_addr[i], obs_dat[i], exp_we[i], exp_busy[i], exp_addr[i], exp_dat[i]);
                end
            end
            if (mx == 159) begin
                mx = 0;
                my = (my == 119) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 8'(mx) || mx != 2) begin
            n_fail++;
            $display("FAIL autoinc_x0: read %0d, expected 2", rd);
        end
        bus_read(3'd1, rd);
        n_checks++;
        if (rd !== 8'(my)) begin
            n_fail++;
            $display("FAIL autoinc_y0: read %0d, expected %0d", rd, my);
        end
        bus_write(3'd7, 8'h00);
    endtask

    task automatic test_errors;
        logic [7:0] rd;
        int waited;
        bus_write(3'd0, 8'd2);
        bus_write(3'd1, 8'd3);
        bus_write(3'd4, 8'd4);
        bus_write(3'd5, 8'd4);
        bus_write(3'd3, 8'h02);
        bus_write(3'd0, 8'h77);
        bus_read(3'd6, rd);
        n_checks++;
        if (rd !== 8'h03) begin
            n_fail++;
            $display("FAIL err_busy_status: read %h, expected 03", rd);
        end
        // A clear that arrives while busy is itself an error, so ERR must survive it.
        bus_write(3'd3, 8'h80);
        bus_read(3'd6, rd);
        n_checks++;
        if (rd !== 8'h03) begin
            n_fail++;
            $display("FAIL err_clear_while_busy: read %h, expected 03", rd);
        end
        waited = 0;
        while (busy === 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_wait_idle: busy=%b after %0d cycles, expected 0", busy, waited);
        end
        bus_read(3'd0, rd);
        n_checks++;
        if (rd !== 8'd2) begin
            n_fail++;
            $display("FAIL err_x0_kept: read %h, expected 02", rd);
        end
        bus_write(3'd3, 8'h80);
        bus_read(3'd6, rd);
        n_checks++;
        if (rd !== 8'h00) begin
            n_fail++;
            $display("FAIL err_cleared: read %h, expected 00", rd);
        end
        bus_write(3'd0, 8'd5);
        bus_write(3'd3, 8'h02);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (fb_we !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL err_bad_rect c%0d: fb_we=%b busy=%b, expected 0 0", i, fb_we, busy);
            end
        end
        bus_read(3'd6, rd);
        n_checks++;
        if (rd !== 8'h02) begin
            n_fail++;
            $display("FAIL err_bad_rect_status: read %h, expected 02", rd);
        end
        bus_write(3'd3, 8'h80);
    endtask

    task automatic test_reset_mid_fill;
        logic [7:0] rd;
        int stray;
        bus_write(3'd0, 8'd2);
        bus_write(3'd1, 8'd3);
        bus_write(3'd4, 8'd4);
        bus_write(3'd5, 8'd4);
        bus_write(3'd2, 8'h5A);
        bus_write(3'd3, 8'h02);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fb_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_fill: fb_we=%b busy=%b, expected 0 0", fb_we, busy);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            n_checks++;
            if (rd !== 8'h00) begin
                n_fail++;
                $display("FAIL rst_mid_reg%0d: read %h, expected 00", i, rd);
            end
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (fb_we !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_writes: %0d active cycles, expected 0", stray);
        end
    endtask

    task automatic test_random;
        int x0, y0, x1, y1, mode;
        logic [7:0] col, cmd;
        for (int t = 0; t < 12; t++) begin
            mode = $urandom_range(0, 2);
            x0   = $urandom_range(0, 165);
            y0   = $urandom_range(0, 124);
            x1   = x0 + $urandom_range(0, 3);
            y1   = y0 + $urandom_range(0, 2);
            col  = 8'($urandom_range(0, 255));
            cmd  = (mode == 0) ? 8'h01 : ((mode == 1) ? 8'h02 : 8'h03);
            bus_write(3'd0, 8'(x0));
            bus_write(3'd1, 8'(y0));
            bus_write(3'd4, 8'(x1));
            bus_write(3'd5, 8'(y1));
            bus_write(3'd2, col);
            bus_write(3'd3, cmd);
            if (mode == 0) build_expect(x0, y0, x0, y0, col);
            else           build_expect(x0, y0, x1, y1, col);
            capture(exp_we.size());
            for (int i = 0; i < exp_we.size(); i++) begin
                n_checks++;
                if (obs_we[i] !== exp_we[i] || obs_busy[i] !== exp_busy[i] ||
                    (exp_we[i] && (obs_addr[i] !== exp_addr[i] || obs_dat[i] !== exp_dat[i]))) begin
                    n_fail++;
                    $display("FAIL random%0d cmd=%h c%0d: we=%b busy=%b addr=%h dat=%h, expected we=%b busy=%b addr=%h dat=%h",
                             t, cmd, i, obs_we[i], obs_busy[i], obs_addr[i], obs_dat[i], exp_we[i], exp_busy[i], exp_addr[i], exp_dat[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_plot;
        test_fill;
        test_autoinc;
        test_errors;
        test_random;
        test_reset_mid_fill;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
